// File: rtl/hex_disp_pkg.sv
// Shared definitions for the multiplexed hex display controller:
// blank pattern, controller state encoding and the 7-segment font.
package hex_disp_pkg;

    // All segments off (segments are active-low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        SCAN   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    // Active-low patterns, bit 6 = g ... bit 0 = a, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/segment7.sv
// Hex nibble to active-low 7-segment pattern decoder (pure combinational).
module segment7
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scan_ctrl.sv
// Multiplexed hex display controller: holds an NDIGITS-nibble display value,
// time-multiplexes it onto a shared segment bus and accepts new values via a
// valid/ready handshake. Optional feature macro: LEADING_ZERO_BLANK_EN
// (blanks zero digits above the most significant nonzero digit).
module hex_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int SCAN_DIV = 50000
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    input  logic [4*NDIGITS-1:0]   load_data,
    output logic                   load_ready,
    output logic [6:0]             hex,
    output logic [NDIGITS-1:0]     digit_en,
    output logic                   frame_done
);

    localparam int IW = $clog2(NDIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NDIGITS - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [4*NDIGITS-1:0] disp_q;
    logic                 handshake;
    logic                 frame_d;
    logic [3:0]           cur_nibble;
    logic [6:0]           seg_pat;
    logic [NDIGITS-1:0]   lzb_mask;

    // Next state, next digit index, prescaler and frame-end detection.
    // load_ready is low only in UPDATE and in the first cycle after reset;
    // that first cycle is a start edge that shows digit 0 without counting,
    // so every slot (including the first one) lasts SCAN_DIV cycles.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        idx_d     = idx_q;
        presc_d   = presc_q;
        frame_d   = 1'b0;
        handshake = load_valid && load_ready;
        unique case (state_q)
            SCAN: begin
                if (handshake) begin
                    state_d = UPDATE;
                end else if (load_ready) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (idx_q == IDX_MAX) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            UPDATE: begin
                state_d = SCAN;
                idx_d   = '0;
                presc_d = '0;
            end
            default: state_d = SCAN;
        endcase
    end

    // Leading-zero mask: digit i is blank when it and every digit above it are zero.
    always_comb begin
        lzb_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = NDIGITS - 1; i > 0; i--) begin
                zero_run    = zero_run && (disp_q[4*i +: 4] == 4'h0);
                lzb_mask[i] = zero_run;
            end
        end
`endif
    end

    // The decoder looks at the digit that will be shown after this edge, so
    // hex and digit_en register together with no skew cycle.
    assign cur_nibble = disp_q[{idx_d, 2'b00} +: 4];

    segment7 u_segment7 (
        .nibble (cur_nibble),
        .seg    (seg_pat)
    );

    // Control state and display register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCAN;
            idx_q   <= '0;
            presc_q <= '0;
            // NOTE: the display register is reset because reset must discard any shown value.
            disp_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            if (handshake) begin
                disp_q <= load_data;
            end
        end
    end

    // Registered outputs, computed from the next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_ready <= 1'b0;
            frame_done <= 1'b0;
            digit_en   <= '0;
            hex        <= SEG_BLANK;
        end else begin
            load_ready <= (state_d == SCAN);
            frame_done <= frame_d;
            if (state_d == SCAN) begin
                digit_en <= NDIGITS'(1) << idx_d;
                hex      <= lzb_mask[idx_d] ? SEG_BLANK : seg_pat;
            end else begin
                digit_en <= '0;
                hex      <= SEG_BLANK;
            end
        end
    end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  new display value offered.
REQ-006 SHALL have port load_data  input  4*NDIGITS  nibble i drives digit i; digit 0 is the least significant.
REQ-007 SHALL have port load_ready  output  1  controller can accept load_data.
REQ-008 SHALL have port hex  output  7  shared segment bus, active-low; bit 0 = segment a.
REQ-009 SHALL have port digit_en  output  NDIGITS  one-hot digit select, active-high.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last digit slot of each scan frame.

Function
REQ-011 SHALL hold a display register (4*NDIGITS bits) that is written only on a handshake, when load_valid and load_ready are both high on a rising edge.
REQ-012 SHALL run a two-state FSM. In SCAN: load_ready=1 and digits are cycled. In UPDATE: load_ready=0, digit_en=0 and hex=7'b1111111, for exactly one cycle.
REQ-013 SCAN -> UPDATE SHALL occur on a handshake. UPDATE -> SCAN SHALL occur unconditionally on the next cycle.
REQ-014 On leaving UPDATE, the digit index SHALL restart at 0 and the prescaler SHALL restart at 0.
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 and wrap. At wrap, the digit index SHALL advance; index NDIGITS-1 SHALL wrap to 0.
REQ-016 frame_done SHALL pulse high for 1 cycle in the cycle after index NDIGITS-1 wraps to 0. It SHALL never pulse in UPDATE.
REQ-017 digit_en SHALL equal 1<<index in SCAN. It SHALL be registered, so it changes on the same edge as the index.
REQ-018 hex SHALL be the segment pattern of the nibble for the current index, decoded through one shared decoder. It SHALL be registered and aligned with digit_en, with no skew cycle.
REQ-019 The decoder patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 If load_valid is held high continuously, it SHALL be accepted once in SCAN, then again each time SCAN resumes (every 2 cycles). The last accepted value wins.
REQ-021 load_data SHALL be sampled only on the handshake edge. Changes on load_data at any other time SHALL have no effect.

Reset
REQ-022 While reset is high, the block SHALL immediately and asynchronously force: state=SCAN, index=0, prescaler=0, display register=0, digit_en=0, hex=7'b1111111, frame_done=0, load_ready=0.
REQ-023 On the first rising edge after reset deasserts, load_ready SHALL rise to 1, and scanning SHALL begin with digit 0 showing "0".
REQ-024 Reset asserted mid-frame or in UPDATE SHALL discard the display contents and any in-flight handshake.

Configuration
REQ-025 With LEADING_ZERO_BLANK_EN defined, zero nibbles above the most significant nonzero nibble SHALL drive hex=7'b1111111 in their slot, with digit_en still active. Digit 0 SHALL never be blanked.
REQ-026 With LEADING_ZERO_BLANK_EN undefined, every digit SHALL show its decoded nibble, including leading zeros.

Structure
REQ-027 A shared package hex_disp_pkg SHALL hold: SEG_BLANK=7'b1111111, the state enumeration {SCAN, UPDATE}, and the 16-entry segment pattern constant.
REQ-028 The block SHALL instantiate exactly one sub-module, segment7 (4-bit in, 7-bit active-low out), fed by the mux of the current nibble.
REQ-029 The leading-zero mask SHALL be computed combinationally from the display register, not per-slot state.

Verification
REQ-030 Reset with NDIGITS=4, SCAN_DIV=4 -> digit_en=0000, hex=1111111 during reset; then digit_en 0001,0010,0100,1000 each held 4 cycles, hex=1000000 throughout.
REQ-031 Load 16'h12AF -> one UPDATE cycle with load_ready=0 and digit_en=0; then digit0 shows F=0001110, digit1 A=0001000, digit2 2=0100100, digit3 1=1111001.
REQ-032 frame_done check -> exactly one pulse every 16 cycles with SCAN_DIV=4, NDIGITS=4; no pulse when a load lands on the last slot.
REQ-033 load_valid held high for 6 cycles with data 1,2,3,4,5,6 -> accepted on cycles 0, 2 and 4; the display ends holding 5.
REQ-034 LEADING_ZERO_BLANK_EN with load 16'h0030 -> digits 3 and 2 show 1111111, digit1 shows 0110000, digit0 shows 1000000. Without the macro, all four digits are decoded.
REQ-035 Reset pulsed mid-frame after loading 16'hBEEF -> outputs are blank immediately; after release, all digits show 0.
